isa_decode_stage: RTL and testbench

ISA_DECODE_STAGE -- requirements
Module: isa_decode_stage

---
 rtl/isa_decode_stage_pkg.sv | 68 ++++++
 rtl/isa_decode_stage_vrf_addr_gen.sv | 30 +++
 rtl/isa_decode_stage.sv | 191 +++++++++++++++++++
 tb/tb_isa_decode_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_decode_stage_pkg.sv
// Shared decode definitions: instruction classes, opcode/funct fields, ALU op codes
// and the decode-stage FSM states.
package isa_decode_stage_pkg;

    localparam int unsigned OPCLASS_W     = 4;
    localparam int unsigned REG_IDX_W     = 5;
    localparam int unsigned OP_W          = 3;
    localparam int unsigned VLEN_CFG_W    = 3;
    localparam int unsigned ILLEGAL_CNT_W = 16;
    localparam int unsigned BRANCH_IMM_W  = 12;

    typedef enum logic [OPCLASS_W-1:0] {
        OPC_ILLEGAL    = 4'd0,
        OPC_VMACC      = 4'd1,
        OPC_VMV_VI     = 4'd2,
        OPC_VSETIVLI   = 4'd3,
        OPC_VLE32      = 4'd4,
        OPC_VSE32      = 4'd5,
        OPC_VSTREAMOUT = 4'd6,
        OPC_BNE        = 4'd7,
        OPC_ADDI       = 4'd8,
        OPC_LUI        = 4'd9,
        OPC_CSR        = 4'd10,
        OPC_ADD        = 4'd11,
        OPC_WFI        = 4'd12
    } opclass_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WFI_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } dec_state_e;

    localparam logic [6:0] OPCODE_VEC     = 7'h57;
    localparam logic [6:0] OPCODE_VLOAD   = 7'h07;
    localparam logic [6:0] OPCODE_VSTORE  = 7'h27;
    localparam logic [6:0] OPCODE_VSTREAM = 7'h7F;
    localparam logic [6:0] OPCODE_BRANCH  = 7'h63;
    localparam logic [6:0] OPCODE_OPIMM   = 7'h13;
    localparam logic [6:0] OPCODE_LUI     = 7'h37;
    localparam logic [6:0] OPCODE_CSR     = 7'h03;
    localparam logic [6:0] OPCODE_OP      = 7'h33;

    localparam logic [2:0]  F3_VMACC    = 3'd0;
    localparam logic [2:0]  F3_VMV_VI   = 3'd5;
    localparam logic [2:0]  F3_VSETIVLI = 3'd7;
    localparam logic [2:0]  F3_BNE      = 3'd1;
    localparam logic [2:0]  F3_ADDI     = 3'd0;
    localparam logic [2:0]  F3_ADD      = 3'd0;
    localparam logic [6:0]  F7_ADD      = 7'd0;
    localparam logic [11:0] CSR_ADDR    = 12'hC00;
    localparam logic [31:0] INSTR_WFI   = 32'h10500073;

    localparam logic [OP_W-1:0] OPS_LUI  = 3'd0;
    localparam logic [OP_W-1:0] OPS_ADDI = 3'd1;
    localparam logic [OP_W-1:0] OPS_BNE  = 3'd2;
    localparam logic [OP_W-1:0] OPS_ADD  = 3'd3;
    localparam logic [OP_W-1:0] OPS_NOP  = 3'd4;
    localparam logic [OP_W-1:0] OPV_MACC = 3'd3;
    localparam logic [OP_W-1:0] OPV_NOP  = 3'd4;

    // Classes that occupy the vector datapath and must wait for vec_busy to drop.
    function automatic logic is_vector(opclass_e cls);
        return cls inside {OPC_VMACC, OPC_VMV_VI, OPC_VSETIVLI,
                           OPC_VLE32, OPC_VSE32, OPC_VSTREAMOUT};
    endfunction

endpackage

// File: rtl/isa_decode_stage_vrf_addr_gen.sv
// Vector RF base address: register index masked to the chunk-size field width
// and shifted up so each chunk owns an aligned slice of the RF.
module vrf_addr_gen
    import isa_decode_stage_pkg::*;
#(
    parameter int unsigned DWIDTH_RFADD = 12
)(
    input  logic [REG_IDX_W-1:0]    reg_idx,
    input  logic [VLEN_CFG_W-1:0]   cfg,
    output logic [DWIDTH_RFADD-1:0] addr_c
);

    logic [REG_IDX_W-1:0] mask_c;
    logic [4:0]           shamt_c;

    always_comb begin
        mask_c = 5'h1F;
        case (cfg)
            3'd0:    mask_c = 5'h01;
            3'd1:    mask_c = 5'h03;
            3'd2:    mask_c = 5'h07;
            3'd3:    mask_c = 5'h0F;
            default: mask_c = 5'h1F;
        endcase
    end

    assign shamt_c = 5'(DWIDTH_RFADD - 1) - 5'(cfg);
    assign addr_c  = DWIDTH_RFADD'(reg_idx & mask_c) << shamt_c;

endmodule

// File: rtl/isa_decode_stage.sv
// Single-stage instruction decoder between fetch and the CGRA execute datapath,
// with wfi/halt sequencing and a saturating illegal-instruction counter.
module isa_decode_stage
    import isa_decode_stage_pkg::*;
#(
    parameter int unsigned DWIDTH_INST  = 32,
    parameter int unsigned DWIDTH_RFADD = 12,
    parameter int unsigned DWIDTH_INT   = 32
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DWIDTH_INST-1:0]   in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     vec_busy,
    input  logic                     done_steady,
    input  logic                     ap_start,
    output logic [3:0]               out_opclass,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [4:0]               out_rd,
    output logic [DWIDTH_RFADD-1:0]  out_vr_addr,
    output logic [DWIDTH_RFADD-1:0]  out_vw_addr,
    output logic [DWIDTH_INT-1:0]    out_imm,
    output logic [11:0]              out_branch_imm,
    output logic [2:0]               out_op_vec,
    output logic [2:0]               out_op_scalar,
    output logic                     out_wen_scalar,
    output logic [DWIDTH_RFADD-1:0]  out_itr,
    output logic [2:0]               vlen_cfg,
    output logic                     ap_done,
    output logic [15:0]              illegal_cnt
);

    logic [31:0]              instr;
    opclass_e                 cls_c;
    dec_state_e               state, state_next;
    logic                     accept_c;
    logic                     ap_done_next_c;
    logic [REG_IDX_W-1:0]     vs2_c, vd_c;
    logic [DWIDTH_RFADD-1:0]  vr_addr_c, vw_addr_c;
    logic [DWIDTH_INT-1:0]    imm_c;
    logic [OP_W-1:0]          op_scalar_c, op_vec_c;
    logic                     wen_c;

    assign instr = 32'(in_instr);

    // Instruction class decode.
    always_comb begin
        cls_c = OPC_ILLEGAL;
        if (instr == INSTR_WFI) begin
            cls_c = OPC_WFI;
        end else begin
            case (instr[6:0])
                OPCODE_VEC: begin
                    case (instr[14:12])
                        F3_VMACC:    cls_c = OPC_VMACC;
                        F3_VMV_VI:   cls_c = OPC_VMV_VI;
                        F3_VSETIVLI: cls_c = OPC_VSETIVLI;
                        default:     cls_c = OPC_ILLEGAL;
                    endcase
                end
                OPCODE_VLOAD:   cls_c = OPC_VLE32;
                OPCODE_VSTORE:  cls_c = OPC_VSE32;
                OPCODE_VSTREAM: cls_c = OPC_VSTREAMOUT;
                OPCODE_BRANCH:  if (instr[14:12] == F3_BNE)  cls_c = OPC_BNE;
                OPCODE_OPIMM:   if (instr[14:12] == F3_ADDI) cls_c = OPC_ADDI;
                OPCODE_LUI:     cls_c = OPC_LUI;
                OPCODE_CSR:     if (instr[31:20] == CSR_ADDR) cls_c = OPC_CSR;
                OPCODE_OP:      if (instr[14:12] == F3_ADD && instr[31:25] == F7_ADD) cls_c = OPC_ADD;
                default:        cls_c = OPC_ILLEGAL;
            endcase
        end
    end

    // Immediate, op codes and write enable per class; ILLEGAL falls out as a NOP.
    always_comb begin
        imm_c       = '0;
        op_scalar_c = OPS_NOP;
        op_vec_c    = OPV_NOP;
        wen_c       = 1'b0;
        case (cls_c)
            OPC_VMACC: op_vec_c = OPV_MACC;
            OPC_BNE:   op_scalar_c = OPS_BNE;
            OPC_ADDI: begin
                imm_c       = DWIDTH_INT'($signed(instr[31:20]));
                op_scalar_c = OPS_ADDI;
                wen_c       = 1'b1;
            end
            OPC_LUI: begin
                imm_c       = DWIDTH_INT'({instr[31:12], 12'h000});
                op_scalar_c = OPS_LUI;
                wen_c       = 1'b1;
            end
            OPC_CSR: wen_c = 1'b1;
            OPC_ADD: begin
                op_scalar_c = OPS_ADD;
                wen_c       = 1'b1;
            end
            default: ;
        endcase
    end

    assign vs2_c = (cls_c == OPC_VSE32) ? instr[11:7] : instr[24:20];
    assign vd_c  = instr[11:7];

    vrf_addr_gen #(.DWIDTH_RFADD(DWIDTH_RFADD)) u_vr_addr (
        .reg_idx (vs2_c),
        .cfg     (vlen_cfg),
        .addr_c  (vr_addr_c)
    );

    vrf_addr_gen #(.DWIDTH_RFADD(DWIDTH_RFADD)) u_vw_addr (
        .reg_idx (vd_c),
        .cfg     (vlen_cfg),
        .addr_c  (vw_addr_c)
    );

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready)
                      && !(is_vector(cls_c) && vec_busy);
    assign accept_c = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    // Halt sequencing; ap_done is raised on the WFI_WAIT->HALT transition only.
    always_comb begin
        state_next     = state;
        ap_done_next_c = 1'b0;
        case (state)
            ST_RUN:      if (accept_c && cls_c == OPC_WFI) state_next = ST_WFI_WAIT;
            ST_WFI_WAIT: if (done_steady && !out_valid) begin
                             state_next     = ST_HALT;
                             ap_done_next_c = 1'b1;
                         end
            ST_HALT:     if (ap_start) state_next = ST_RUN;
            default:     state_next = ST_RUN;
        endcase
    end

    // Output pipeline register; fields only load on acceptance so a stall holds them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_opclass    <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_rd         <= '0;
            out_vr_addr    <= '0;
            out_vw_addr    <= '0;
            out_imm        <= '0;
            out_branch_imm <= '0;
            out_op_vec     <= '0;
            out_op_scalar  <= '0;
            out_wen_scalar <= 1'b0;
            out_itr        <= '0;
            vlen_cfg       <= '0;
            ap_done        <= 1'b0;
            illegal_cnt    <= '0;
        end else begin
            ap_done <= ap_done_next_c;
            if (accept_c) begin
                out_valid      <= 1'b1;
                out_opclass    <= cls_c;
                out_rs1        <= instr[19:15];
                out_rs2        <= instr[24:20];
                out_rd         <= instr[11:7];
                out_vr_addr    <= vr_addr_c;
                out_vw_addr    <= vw_addr_c;
                out_imm        <= imm_c;
                out_branch_imm <= {instr[31], instr[7], instr[30:25], instr[11:8]};
                out_op_vec     <= op_vec_c;
                out_op_scalar  <= op_scalar_c;
                out_wen_scalar <= wen_c;
                if (cls_c == OPC_VSETIVLI) begin
                    vlen_cfg <= instr[17:15];
                    out_itr  <= DWIDTH_RFADD'(instr[29:18]);
                end
                if (cls_c == OPC_ILLEGAL && illegal_cnt != 16'hFFFF)
                    illegal_cnt <= illegal_cnt + 16'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_isa_decode_stage.sv
// Directed and randomized checks of isa_decode_stage against a behavioural decode model.
module tb_isa_decode_stage;
    import isa_decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_instr;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        vec_busy, done_steady, ap_start;
    logic [3:0]  out_opclass;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [11:0] out_vr_addr, out_vw_addr, out_itr, out_branch_imm;
    logic [31:0] out_imm;
    logic [2:0]  out_op_vec, out_op_scalar, vlen_cfg;
    logic        out_wen_scalar, ap_done;
    logic [15:0] illegal_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0]  opclass;
        logic [4:0]  rs1, rs2, rd;
        logic [11:0] vr, vw;
        logic [31:0] imm;
        logic [11:0] bimm;
        logic [2:0]  opv, ops;
        logic        wen;
    } exp_t;

    isa_decode_stage dut (
        .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .vec_busy(vec_busy),
        .done_steady(done_steady), .ap_start(ap_start), .out_opclass(out_opclass),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_vr_addr(out_vr_addr),
        .out_vw_addr(out_vw_addr), .out_imm(out_imm), .out_branch_imm(out_branch_imm),
        .out_op_vec(out_op_vec), .out_op_scalar(out_op_scalar), .out_wen_scalar(out_wen_scalar),
        .out_itr(out_itr), .vlen_cfg(vlen_cfg), .ap_done(ap_done), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode written straight from the instruction-set rules.
    function automatic exp_t model_decode(input logic [31:0] i, input int cfg);
        exp_t e;
        int op, f3, w, sh, vs2, vd;
        op = int'(i[6:0]);
        f3 = int'(i[14:12]);
        e.opclass = OPC_ILLEGAL;
        if (i == 32'h10500073)                                    e.opclass = OPC_WFI;
        else if (op == 'h57 && f3 == 0)                           e.opclass = OPC_VMACC;
        else if (op == 'h57 && f3 == 5)                           e.opclass = OPC_VMV_VI;
        else if (op == 'h57 && f3 == 7)                           e.opclass = OPC_VSETIVLI;
        else if (op == 'h07)                                      e.opclass = OPC_VLE32;
        else if (op == 'h27)                                      e.opclass = OPC_VSE32;
        else if (op == 'h7F)                                      e.opclass = OPC_VSTREAMOUT;
        else if (op == 'h63 && f3 == 1)                           e.opclass = OPC_BNE;
        else if (op == 'h13 && f3 == 0)                           e.opclass = OPC_ADDI;
        else if (op == 'h37)                                      e.opclass = OPC_LUI;
        else if (op == 'h03 && i[31:20] == 12'hC00)               e.opclass = OPC_CSR;
        else if (op == 'h33 && f3 == 0 && i[31:25] == 7'd0)       e.opclass = OPC_ADD;
        e.rs1  = i[19:15];
        e.rs2  = i[24:20];
        e.rd   = i[11:7];
        e.bimm = {i[31], i[7], i[30:25], i[11:8]};
        w   = (cfg + 1 < 5) ? cfg + 1 : 5;
        sh  = 12 - cfg - 1;
        vs2 = (e.opclass == OPC_VSE32) ? int'(i[11:7]) : int'(i[24:20]);
        vd  = int'(i[11:7]);
        e.vr  = 12'((vs2 % (1 << w)) << sh);
        e.vw  = 12'((vd % (1 << w)) << sh);
        e.imm = 32'd0;
        e.ops = 3'd4;
        e.opv = 3'd4;
        e.wen = 1'b0;
        case (e.opclass)
            OPC_VMACC: e.opv = 3'd3;
            OPC_BNE:   e.ops = 3'd2;
            OPC_ADDI:  begin e.imm = {{20{i[31]}}, i[31:20]}; e.ops = 3'd1; e.wen = 1'b1; end
            OPC_LUI:   begin e.imm = {i[31:12], 12'h000};    e.ops = 3'd0; e.wen = 1'b1; end
            OPC_CSR:   e.wen = 1'b1;
            OPC_ADD:   begin e.ops = 3'd3; e.wen = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic model_is_vec(input logic [3:0] cls);
        return (cls == OPC_VMACC) || (cls == OPC_VMV_VI) || (cls == OPC_VSETIVLI) ||
               (cls == OPC_VLE32) || (cls == OPC_VSE32) || (cls == OPC_VSTREAMOUT);
    endfunction

    function automatic exp_t dut_fields();
        exp_t e;
        e.opclass = out_opclass;  e.rs1 = out_rs1;        e.rs2 = out_rs2;
        e.rd      = out_rd;       e.vr  = out_vr_addr;    e.vw  = out_vw_addr;
        e.imm     = out_imm;      e.bimm = out_branch_imm;
        e.opv     = out_op_vec;   e.ops = out_op_scalar;  e.wen = out_wen_scalar;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 12);
        case (k)
            0:  begin r[6:0] = 7'h57; r[14:12] = 3'd0; end
            1:  begin r[6:0] = 7'h57; r[14:12] = 3'd5; end
            2:  begin r[6:0] = 7'h57; r[14:12] = 3'd7; end
            3:  r[6:0] = 7'h07;
            4:  r[6:0] = 7'h27;
            5:  r[6:0] = 7'h7F;
            6:  begin r[6:0] = 7'h63; r[14:12] = 3'd1; end
            7:  begin r[6:0] = 7'h13; r[14:12] = 3'd0; end
            8:  r[6:0] = 7'h37;
            9:  begin r[6:0] = 7'h03; r[31:20] = 12'hC00; end
            10: begin r[6:0] = 7'h33; r[14:12] = 3'd0; r[31:25] = 7'd0; end
            default: ;
        endcase
        if (r == 32'h10500073) r = 32'h0;
        return r;
    endfunction

    initial begin
        exp_t        e, mout;
        logic        mvalid, exp_rdy, acc;
        logic [2:0]  mcfg;
        logic [11:0] mitr;
        int          mcnt, pulses;
        logic [31:0] ri;

        rst = 1'b1; in_instr = '0; in_valid = 0; out_ready = 1; vec_busy = 0;
        done_steady = 0; ap_start = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fields", dut_fields(), '0);
        chk("rst_cfg_itr", {vlen_cfg, out_itr}, 0);
        chk("rst_cnt_done", {illegal_cnt, ap_done}, 0);
        rst = 1'b0;

        // vsetivli then vmacc back to back: vmacc sees the new chunk config
        in_valid = 1; in_instr = 32'h00017057;
        #1 chk("cfg_in_ready", in_ready, 1);
        tick();
        chk("cfg_vlen", vlen_cfg, 3'd2);
        chk("cfg_opclass", out_opclass, OPC_VSETIVLI);
        in_instr = 32'h003002D7;
        #1 chk("vmacc_in_ready", in_ready, 1);
        tick();
        chk("vmacc_vr", out_vr_addr, 12'h600);
        chk("vmacc_vw", out_vw_addr, 12'hA00);
        chk("vmacc_opv", out_op_vec, 3'd3);
        chk("vmacc_valid", out_valid, 1);

        // addi with negative immediate, one cycle latency
        in_instr = 32'hFFF00093;
        tick();
        chk("addi_valid", out_valid, 1);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_rd", out_rd, 5'd1);
        chk("addi_wen_ops", {out_wen_scalar, out_op_scalar}, {1'b1, 3'd1});
        in_valid = 0;
        tick();
        chk("addi_drain", out_valid, 0);

        // downstream stall holds vmacc and blocks the next instruction
        out_ready = 0; in_valid = 1; in_instr = 32'h003002D7;
        tick();
        in_instr = 32'h00500093;
        for (int s = 0; s < 3; s++) begin
            #1 chk("stall_in_ready", in_ready, 0);
            tick();
            chk("stall_hold", dut_fields(), model_decode(32'h003002D7, 2));
            chk("stall_valid", out_valid, 1);
        end
        out_ready = 1;
        #1 chk("unstall_in_ready", in_ready, 1);
        tick();
        chk("unstall_addi", dut_fields(), model_decode(32'h00500093, 2));
        in_valid = 0;
        tick();
        chk("unstall_once", out_valid, 0);

        // vector instruction blocked by vec_busy, scalar passes
        vec_busy = 1; in_valid = 1; in_instr = 32'h00306287;
        #1 chk("vbusy_vle_ready", in_ready, 0);
        tick();
        chk("vbusy_vle_valid", out_valid, 0);
        in_instr = 32'h00500093;
        #1 chk("vbusy_addi_ready", in_ready, 1);
        tick();
        chk("vbusy_addi", out_opclass, OPC_ADDI);
        vec_busy = 0;

        // three all-zero words are illegal NOPs
        in_instr = 32'h0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("illegal_cnt", illegal_cnt, 16'(k));
            chk("illegal_nop", {out_opclass, out_wen_scalar, out_op_scalar, out_op_vec},
                {OPC_ILLEGAL, 1'b0, 3'd4, 3'd4});
        end

        // reset mid-transfer clears everything asynchronously
        out_ready = 0; in_instr = 32'h003002D7;
        tick();
        in_instr = 32'h00500093;
        #2 rst = 1;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_fields", dut_fields(), '0);
        chk("mrst_state", {vlen_cfg, out_itr, illegal_cnt, ap_done}, 0);
        in_valid = 0; out_ready = 1;
        #2 rst = 0;
        tick();
        chk("mrst_discard", out_valid, 0);
        chk("mrst_run", in_ready, 1);

        // wfi: drain, wait for done_steady, single ap_done, halt until ap_start
        in_valid = 1; in_instr = 32'h10500073;
        #1 chk("wfi_in_ready", in_ready, 1);
        tick();
        chk("wfi_issued", out_opclass, OPC_WFI);
        in_valid = 0; in_instr = 32'h0;
        for (int c = 0; c < 3; c++) begin
            ap_start = (c == 1);
            tick();
            chk("wfi_wait_ready", in_ready, 0);
            chk("wfi_wait_done", ap_done, 0);
        end
        ap_start = 0; done_steady = 1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ap_done) pulses++;
            chk("halt_ready", in_ready, 0);
        end
        chk("ap_done_pulses", 32'(pulses), 1);
        ap_start = 1;
        tick();
        ap_start = 0; done_steady = 0;
        #1 chk("restart_ready", in_ready, 1);

        // wfi pending at reset must not produce ap_done
        in_valid = 1; in_instr = 32'h10500073;
        tick();
        in_valid = 0; in_instr = 32'h0;
        tick();
        #2 rst = 1;
        #2 rst = 0;
        done_steady = 1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ap_done) pulses++;
        end
        chk("rst_wfi_no_done", 32'(pulses), 0);
        chk("rst_wfi_run", in_ready, 1);
        done_steady = 0;

        // randomized traffic against the model
        mvalid = 0; mout = '0; mcfg = 3'd0; mitr = 12'd0; mcnt = 0;
        for (int n = 0; n < 400; n++) begin
            ri = rand_instr();
            in_instr  = ri;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            vec_busy  = ($urandom_range(0, 9) < 3);
            #1;
            e = model_decode(ri, int'(mcfg));
            exp_rdy = (!mvalid || out_ready) && !(model_is_vec(e.opclass) && vec_busy);
            chk("rnd_in_ready", in_ready, exp_rdy);
            acc = in_valid && exp_rdy;
            tick();
            if (acc) begin
                mvalid = 1;
                mout = e;
                if (e.opclass == OPC_VSETIVLI) begin
                    mcfg = ri[17:15];
                    mitr = ri[29:18];
                end
                if (e.opclass == OPC_ILLEGAL && mcnt < 65535) mcnt++;
            end else if (out_ready) begin
                mvalid = 0;
            end
            chk("rnd_out_valid", out_valid, mvalid);
            if (mvalid) chk("rnd_fields", dut_fields(), mout);
            chk("rnd_cfg_itr", {vlen_cfg, out_itr}, {mcfg, mitr});
            chk("rnd_illegal_cnt", illegal_cnt, 16'(mcnt));
            chk("rnd_ap_done", ap_done, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
